// File: rtl/memory_loader.sv
// memory_loader: streams host bytes into program memory over a shared tri-state bus.
// Define LOADER_VERIFY_EN to add a read-back VERIFY cycle after every write.
module memory_loader #(
  parameter int unsigned MEM_DEPTH  = 255,
  parameter logic [7:0]  START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] addr,
  output logic       mem_ie,
  output logic       mem_oe,
  inout  wire  [7:0] bus,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] count
);

  localparam logic [7:0] LastAddr = 8'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWrite,
`ifdef LOADER_VERIFY_EN
    StVerify,
`endif
    StAdvance,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] count_q, count_d;
  logic       error_q, error_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       busy_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StAccept;
          addr_d  = START_ADDR;
          count_d = '0;
          error_d = 1'b0;
        end
      end
      StAccept: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          state_d = StWrite;
        end
      end
      StWrite: begin
`ifdef LOADER_VERIFY_EN
        state_d = StVerify;
`else
        state_d = StAdvance;
`endif
      end
`ifdef LOADER_VERIFY_EN
      StVerify: begin
        // Memory drives the bus this cycle; compare what it returns with what we wrote.
        if (bus != data_q) error_d = 1'b1;
        state_d = StAdvance;
      end
`endif
      StAdvance: begin
        count_d = count_q + 9'd1;
        if (last_q) begin
          state_d = StDone;
        end else if (addr_q == LastAddr) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = StAccept;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d != StIdle) && (state_d != StDone);

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= START_ADDR;
      count_q  <= '0;
      error_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      in_ready <= 1'b0;
      mem_ie   <= 1'b0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      data_q   <= data_d;
      last_q   <= last_d;
      in_ready <= (state_d == StAccept);
      mem_ie   <= (state_d == StWrite);
      cpu_hold <= busy_d;
      busy     <= busy_d;
      done     <= (state_d == StDone);
    end
  end

`ifdef LOADER_VERIFY_EN
  logic mem_oe_q;
  always_ff @(posedge clk) begin
    if (rst) mem_oe_q <= 1'b0;
    else     mem_oe_q <= (state_d == StVerify);
  end
  assign mem_oe = mem_oe_q;
`else
  assign mem_oe = 1'b0;
`endif

  assign bus   = mem_ie ? data_q : 8'bz;
  assign addr  = addr_q;
  assign count = count_q;
  assign error = error_q;

endmodule

// File: tb/tb_memory_loader.sv
// Bench for memory_loader: two instances (default base and base 0xF0) share the host stream,
// each with a behavioural memory and an idle bus keeper that exposes stray bus drive.
module tb_memory_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid, in_last;
  logic [7:0] in_data;
  wire  [7:0] bus, bus_b;
  logic       in_ready, mem_ie, mem_oe, cpu_hold, busy, done, error;
  logic       in_ready_b, mem_ie_b, mem_oe_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [7:0] addr, addr_b;
  logic [8:0] count, count_b;

  memory_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .addr(addr), .mem_ie(mem_ie), .mem_oe(mem_oe),
    .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .count(count)
  );

  memory_loader #(.START_ADDR(8'hF0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready_b), .addr(addr_b), .mem_ie(mem_ie_b),
    .mem_oe(mem_oe_b), .bus(bus_b), .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b),
    .error(error_b), .count(count_b)
  );

`ifdef LOADER_VERIFY_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 3;
`endif

  // Behavioural memories; the keeper value 0x5A is present whenever nobody should drive.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       clr, stuck1, mon_en;
  logic [7:0] clr_val;
  int         bus_bad, oe_seen;

  assign bus   = mem_oe   ? mem_a[addr]   : (mem_ie   ? 8'bz : 8'h5A);
  assign bus_b = mem_oe_b ? mem_b[addr_b] : (mem_ie_b ? 8'bz : 8'h5A);

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= clr_val;
        mem_b[i] <= clr_val;
      end
    end else begin
      if (mem_ie && !(stuck1 && addr == 8'd1)) mem_a[addr] <= bus;
      if (mem_ie_b) mem_b[addr_b] <= bus_b;
    end
    if (mon_en) begin
      if (!mem_ie && !mem_oe && bus !== 8'h5A) bus_bad <= bus_bad + 1;
      if (!mem_ie_b && !mem_oe_b && bus_b !== 8'h5A) bus_bad <= bus_bad + 1;
      if (mem_oe || mem_oe_b) oe_seen <= oe_seen + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem(input logic [7:0] v);
    clr_val = v;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Returns with the sample point just after the accepting edge (loader now in WRITE).
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < budget && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 50 && !done; i++) tick();
    chk(name, int'(done), 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vt [3];
  bit   ok;
  int   acc, rc;
  logic [7:0] q [$];

  initial begin
    vt[0] = '{data: 8'h11, last: 1'b0, exp_addr: 8'h00};
    vt[1] = '{data: 8'h22, last: 1'b0, exp_addr: 8'h01};
    vt[2] = '{data: 8'h33, last: 1'b1, exp_addr: 8'h02};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    clr = 1'b0; clr_val = 8'h00; stuck1 = 1'b0; mon_en = 1'b0; bus_bad = 0; oe_seen = 0;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_addr", int'(addr), 0);
    chk("rst_addr_b", int'(addr_b), 'hF0);
    chk("rst_count", int'(count), 0);
    chk("rst_flags", int'({in_ready, mem_ie, mem_oe, cpu_hold, busy, done, error}), 0);
    chk("rst_bus", int'(bus), 'h5A);

    // Three-byte load from the table
    clear_mem(8'hEE);
    pulse_start();
    chk("hold_after_start", int'({cpu_hold, busy, in_ready}), 'b111);
    for (int i = 0; i < 3; i++) begin
      send_byte(vt[i].data, vt[i].last, 0, 20, ok);
      chk($sformatf("accept_%0d", i), int'(ok), 1);
      chk($sformatf("write_addr_%0d", i), int'(addr), int'(vt[i].exp_addr));
      chk($sformatf("write_ie_%0d", i), int'({mem_ie, in_ready}), 'b10);
    end
    for (int k = 1; k < Lat - 1; k++) tick();
    chk("done_early", int'(done), 0);
    tick();
    chk("done_latency", int'(done), 1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("mem_%0d", i), int'(mem_a[vt[i].exp_addr]), int'(vt[i].data));
    chk("count3", int'(count), 3);
    chk("done_flags", int'({error, cpu_hold, busy, in_ready}), 0);

    // Non-zero base address
    do_reset();
    clear_mem(8'hEE);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hC1 + 8'(i), i == 3, 1, 20, ok);
      chk("accept_b", int'(ok), 1);
    end
    wait_done("done_b_wait");
    chk("done_b", int'(done_b), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("mem_b_%0d", i), int'(mem_b[8'hF0 + i]), 'hC1 + i);
    chk("mem_b_beyond", int'(mem_b[8'hF4]), 'hEE);
    chk("addr_b_hold", int'(addr_b), 'hF3);
    chk("count_b", int'(count_b), 4);
    chk("flags_b", int'({error_b, busy_b, cpu_hold_b, in_ready_b}), 0);

    // Overflow: 256 bytes offered, no in_last
    do_reset();
    clear_mem(8'hEE);
    pulse_start();
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'((i * 7 + 3) & 255), 1'b0, 0, 10, ok);
      if (ok) acc++;
    end
    chk("ovf_accepted", acc, 255);
    chk("ovf_count", int'(count), 255);
    chk("ovf_err_done", int'({error, done, in_ready}), 'b110);
    chk("ovf_addr", int'(addr), 254);
    rc = 0;
    for (int i = 0; i < 255; i++) if (mem_a[i] != 8'((i * 7 + 3) & 255)) rc++;
    chk("ovf_mem_bad", rc, 0);
    chk("ovf_no_wrap", int'(mem_a[255]), 'hEE);

    // Randomised loads restarted from DONE, with ignored start pulses while busy
    for (int t = 0; t < 6; t++) begin
      int len;
      len = int'($urandom_range(1, 8));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      clear_mem(8'hEE);
      pulse_start();
      chk("rnd_err_clr", int'(error), 0);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) pulse_start();
        send_byte(q[i], i == len - 1, int'($urandom_range(0, 3)), 30, ok);
        if (!ok) chk("rnd_accept", 0, 1);
      end
      wait_done("rnd_done");
      chk("rnd_count", int'(count), len);
      chk("rnd_error", int'(error), 0);
      rc = 0;
      for (int i = 0; i < len; i++) begin
        if (mem_a[i] != q[i]) rc++;
        if (mem_b[8'hF0 + i] != q[i]) rc++;
      end
      if (mem_a[len] != 8'hEE) rc++;
      chk("rnd_mem_bad", rc, 0);
    end

    // Host stalls for 20 cycles in ACCEPT
    do_reset();
    clear_mem(8'hEE);
    bus_bad = 0;
    pulse_start();
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) rc++;
      tick();
    end
    chk("stall_ready", rc, 20);
    send_byte(8'hA5, 1'b1, 0, 5, ok);
    wait_done("stall_done");
    chk("stall_mem", int'(mem_a[0]), 'hA5);
    chk("bus_idle", bus_bad, 0);

    // Reset during WRITE of the second byte
    do_reset();
    pulse_start();
    send_byte(8'h77, 1'b0, 0, 10, ok);
    send_byte(8'h88, 1'b0, 0, 10, ok);
    chk("midwrite_ie", int'(mem_ie), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_flags", int'({mem_ie, cpu_hold, busy, done, in_ready, error}), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_bus", int'(bus), 'h5A);
    pulse_start();
    send_byte(8'h99, 1'b1, 0, 10, ok);
    wait_done("reload_done");
    chk("reload_mem", int'(mem_a[0]), 'h99);
    chk("reload_count", int'(count), 1);

`ifdef LOADER_VERIFY_EN
    // Read-back mismatch at address 1
    do_reset();
    clear_mem(8'h00);
    stuck1 = 1'b1;
    pulse_start();
    send_byte(8'h01, 1'b0, 0, 10, ok);
    send_byte(8'h02, 1'b1, 0, 10, ok);
    tick();
    chk("vfy_err_pre", int'({error, mem_oe}), 'b01);
    tick();
    chk("vfy_err_post", int'(error), 1);
    wait_done("vfy_done");
    chk("vfy_count", int'(count), 2);
    chk("vfy_error_sticky", int'(error), 1);
    stuck1 = 1'b0;
`else
    chk("mem_oe_never", oe_seen, 0);
`endif
    chk("bus_idle_all", bus_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
